// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared encodings and field positions for the fetch stage.
package fetch_unit_pkg;
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_FULL = 1'b1;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam logic [31:0] JUMP_REGION_MASK = 32'hF000_0000;
endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel: resolves EX-stage redirect, its target, and the sequential pc+4.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic        i_ex_valid,
  input  logic        i_branch_beq,
  input  logic        i_branch_bne,
  input  logic        i_jump,
  input  logic        i_zero,
  input  logic [31:0] i_branch_target,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_ex_pc4,
  input  logic [31:0] i_pc,
  output logic        o_redirect,
  output logic [31:0] o_target,
  output logic [31:0] o_pc_plus4
);
  // beq/bne only matter when not a jump, so an undriven branch flag cannot leak in
  assign o_redirect = i_ex_valid & (i_jump | (~i_jump & ((i_branch_beq & i_zero) | (i_branch_bne & ~i_zero))));
  assign o_target = i_jump ? ((i_ex_pc4 & JUMP_REGION_MASK) | {4'b0000, i_jump_index, 2'b00})
                           : (i_branch_target & ~32'h3);
  assign o_pc_plus4 = i_pc + 32'd4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, instruction-memory handshake, IF/ID register with a one-entry
// skid buffer for stalls, and EX-resolved redirects that squash IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_ex_valid,
  input  logic        i_branch_beq,
  input  logic        i_branch_bne,
  input  logic        i_jump,
  input  logic        i_zero,
  input  logic [31:0] i_branch_target,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_ex_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic [31:0] o_pc4
);
  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        fetching;
  next_pc_sel u_next_pc_sel (
    .i_ex_valid     (i_ex_valid),
    .i_branch_beq   (i_branch_beq),
    .i_branch_bne   (i_branch_bne),
    .i_jump         (i_jump),
    .i_zero         (i_zero),
    .i_branch_target(i_branch_target),
    .i_jump_index   (i_jump_index),
    .i_ex_pc4       (i_ex_pc4),
    .i_pc           (pc_q),
    .o_redirect     (redirect),
    .o_target       (target),
    .o_pc_plus4     (pc_plus4)
  );
  assign fetching = state_q == S_FETCH;
  assign o_imem_req = fetching & ~i_rst;
  assign o_imem_addr = pc_q;
  assign o_valid = valid_q;
  assign o_instr = instr_q;
  assign o_opcode = instr_q[OPC_MSB:OPC_LSB];
  assign o_pc4 = pc4_q;
  // A consumed instruction with no new word behind it leaves a bubble in IF/ID.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d = pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d = skid_pc4_q;
    if (redirect) begin
      state_d = S_FETCH;
      pc_d = target;
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end else if (fetching) begin
      if (i_imem_valid) begin
        pc_d = pc_plus4;
        if (~i_stall | ~valid_q) begin
          valid_d = 1'b1;
          instr_d = i_imem_rdata;
          pc4_d = pc_plus4;
        end else begin
          skid_instr_d = i_imem_rdata;
          skid_pc4_d = pc_plus4;
          state_d = S_FULL;
        end
      end else if (~i_stall) begin
        valid_d = 1'b0;
        instr_d = NOP_WORD;
      end
    end else if (~i_stall) begin
      state_d = S_FETCH;
      valid_d = 1'b1;
      instr_d = skid_instr_q;
      pc4_d = skid_pc4_q;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      pc_q <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      pc4_q <= 32'h0;
      skid_instr_q <= NOP_WORD;
      skid_pc4_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q <= skid_pc4_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, a stall/redirect corner sequence, and
// random traffic checked against a queue-based model of the fetch stage.
module tb_fetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, mem_en = 1'b0, stall = 1'b0, exv = 1'b0;
  logic beq = 1'b0, bne = 1'b0, jmp = 1'b0, zero = 1'b0;
  logic [31:0] btgt = 32'h0, expc4 = 32'h0;
  logic [25:0] jidx = 26'h0;
  logic imem_req, imem_valid, o_valid;
  logic [31:0] imem_addr, imem_rdata, o_instr, o_pc4;
  logic [5:0] o_opcode;
  int checks = 0, errors = 0;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h8C08_0004 : (32'h2000_0000 | a);
  endfunction
  assign imem_valid = mem_en & imem_req;
  assign imem_rdata = mem_word(imem_addr);
  fetch_unit dut (
    .i_clk(clk), .i_rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_valid(imem_valid), .i_imem_rdata(imem_rdata),
    .i_stall(stall), .i_ex_valid(exv),
    .i_branch_beq(beq), .i_branch_bne(bne), .i_jump(jmp), .i_zero(zero),
    .i_branch_target(btgt), .i_jump_index(jidx), .i_ex_pc4(expc4),
    .o_valid(o_valid), .o_instr(o_instr), .o_opcode(o_opcode), .o_pc4(o_pc4)
  );
  // Model: IF/ID plus skid seen as a FIFO of at most two fetched words.
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t q[$];
  logic [31:0] m_pc = 32'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic model_edge();
    logic take;
    logic acc;
    ent_t e;
    if (rst) begin
      q.delete();
      m_pc = 32'h0;
    end else begin
      take = exv && (jmp || (beq && zero) || (bne && !zero));
      if (take) begin
        q.delete();
        m_pc = jmp ? {expc4[31:28], jidx, 2'b00} : {btgt[31:2], 2'b00};
      end else begin
        acc = mem_en && q.size() < 2;
        if (!stall && q.size() > 0) void'(q.pop_front());
        if (acc) begin
          e.instr = mem_word(m_pc);
          e.pc4 = m_pc + 32'd4;
          q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask
  task automatic check_model();
    logic [31:0] ei;
    ei = (q.size() > 0) ? q[0].instr : 32'h0;
    chk("m_valid", {31'b0, o_valid}, {31'b0, q.size() > 0});
    chk("m_instr", o_instr, ei);
    chk("m_opcode", {26'b0, o_opcode}, {26'b0, ei[31:26]});
    chk("m_req", {31'b0, imem_req}, {31'b0, !rst && q.size() < 2});
    chk("m_addr", imem_addr, m_pc);
    if (q.size() > 0) chk("m_pc4", o_pc4, q[0].pc4);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] btgt;
    logic [31:0] expc4;
    logic [25:0] jidx;
    logic [2:0]  flg;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
  } vec_t;
  vec_t tbl[20];
  initial begin
    // ctl = {rst,en,stall,exv,beq,bne,jmp,zero}; flg = {req,valid,check_pc4}
    tbl[0]  = '{8'b1000_0000, 32'h0,   32'h0,         26'h0,       3'b001, 32'h0,         32'h0,         32'h0};
    tbl[1]  = '{8'b0100_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'h4,         32'h8C08_0004, 32'h4};
    tbl[2]  = '{8'b0100_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'h8,         32'h2000_0004, 32'h8};
    tbl[3]  = '{8'b0110_0000, 32'h0,   32'h0,         26'h0,       3'b011, 32'hC,         32'h2000_0004, 32'h8};
    tbl[4]  = '{8'b0110_0000, 32'h0,   32'h0,         26'h0,       3'b011, 32'hC,         32'h2000_0004, 32'h8};
    tbl[5]  = '{8'b0000_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'hC,         32'h2000_0008, 32'hC};
    tbl[6]  = '{8'b0101_1001, 32'h41,  32'h0,         26'h0,       3'b100, 32'h40,        32'h0,         32'h0};
    tbl[7]  = '{8'b0100_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'h44,        32'h2000_0040, 32'h44};
    tbl[8]  = '{8'b0001_1011, 32'h200, 32'h1000_0008, 26'h10,      3'b100, 32'h1000_0040, 32'h0,         32'h0};
    tbl[9]  = '{8'b0101_0101, 32'h300, 32'h0,         26'h0,       3'b111, 32'h1000_0044, 32'h3000_0040, 32'h1000_0044};
    tbl[10] = '{8'b0010_0010, 32'h400, 32'h0,         26'h3,       3'b111, 32'h1000_0044, 32'h3000_0040, 32'h1000_0044};
    tbl[11] = '{8'b0110_0000, 32'h0,   32'h0,         26'h0,       3'b011, 32'h1000_0048, 32'h3000_0040, 32'h1000_0044};
    tbl[12] = '{8'b0011_1001, 32'h80,  32'h0,         26'h0,       3'b100, 32'h80,        32'h0,         32'h0};
    tbl[13] = '{8'b0110_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'h84,        32'h2000_0080, 32'h84};
    tbl[14] = '{8'b0001_0010, 32'h0,   32'hF000_0000, 26'h3FF_FFFF, 3'b100, 32'hFFFF_FFFC, 32'h0,         32'h0};
    tbl[15] = '{8'b0100_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'h0,         32'hFFFF_FFFC, 32'h0};
    tbl[16] = '{8'b0010_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'h0,         32'hFFFF_FFFC, 32'h0};
    tbl[17] = '{8'b1100_0000, 32'h0,   32'h0,         26'h0,       3'b001, 32'h0,         32'h0,         32'h0};
    tbl[18] = '{8'b0000_0000, 32'h0,   32'h0,         26'h0,       3'b100, 32'h0,         32'h0,         32'h0};
    tbl[19] = '{8'b0100_0000, 32'h0,   32'h0,         26'h0,       3'b111, 32'h4,         32'h8C08_0004, 32'h4};
    for (int i = 0; i < 20; i++) begin
      {rst, mem_en, stall, exv, beq, bne, jmp, zero} = tbl[i].ctl;
      btgt = tbl[i].btgt;
      expc4 = tbl[i].expc4;
      jidx = tbl[i].jidx;
      step();
      chk($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].flg[2]});
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].flg[1]});
      chk($sformatf("v%0d_instr", i), o_instr, tbl[i].instr);
      chk($sformatf("v%0d_opcode", i), {26'b0, o_opcode}, {26'b0, tbl[i].instr[31:26]});
      if (tbl[i].flg[0]) chk($sformatf("v%0d_pc4", i), o_pc4, tbl[i].pc4);
    end
    // Redirect arriving on the same cycle the stall releases a full skid.
    {rst, mem_en, stall, exv, beq, bne, jmp, zero} = 8'b0110_0000;
    step();
    step();
    chk("full_req_low", {31'b0, imem_req}, 32'h0);
    {stall, exv, jmp} = 3'b011;
    expc4 = 32'h0;
    jidx = 26'h100;
    step();
    chk("rel_redir_valid", {31'b0, o_valid}, 32'h0);
    chk("rel_redir_addr", imem_addr, 32'h400);
    {exv, jmp} = 2'b00;
    step();
    chk("rel_redir_instr", o_instr, 32'h2000_0400);
    rst = 1'b1;
    step();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 99) == 0;
      mem_en = $urandom_range(0, 9) < 7;
      stall = $urandom_range(0, 9) < 3;
      exv = $urandom_range(0, 9) < 2;
      beq = $urandom_range(0, 1) == 1;
      bne = $urandom_range(0, 1) == 1;
      jmp = $urandom_range(0, 3) == 0;
      zero = $urandom_range(0, 1) == 1;
      btgt = $urandom;
      expc4 = $urandom;
      jidx = 26'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
